// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, byte/word/block types, the decrypt FSM
// encoding, round constants and the InvShiftRows byte permutation.
package aes_pkg;
  localparam int KEY_SIZE     = 128;
  localparam int BLOCK_LENGTH = 128;
  localparam int ROUNDS       = 10;
  localparam int WORD_SIZE    = 32;

  typedef logic [7:0]              byte_t;
  typedef logic [WORD_SIZE-1:0]    word_t;
  typedef logic [BLOCK_LENGTH-1:0] block_t;

  typedef enum logic [1:0] {IDLE, KEY_FWD, ADD0, ROUND} dec_state_t;

  // Rcon[1..10] in slots 1..10; the spare slots are zero so any 4-bit
  // round index selects a defined value.
  localparam byte_t RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Output byte i of InvShiftRows takes input byte INV_SR_IDX[i]
  // (byte index = 4*column + row, byte 0 in the MSBs).
  localparam int INV_SR_IDX [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  // Cyclic left rotation of a key-schedule word by one byte.
  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns on one 32-bit column; coefficients 0e/0b/0d/09 are
// assembled from the x2, x4, x8 multiples produced by chained xtime.
module inv_mix_column
  import aes_pkg::*;
(
  input  word_t col_i,
  output word_t col_o
);
  byte_t a [4], x2 [4], x4 [4], x8 [4];
  byte_t m9 [4], mb [4], md [4], me [4];

  for (genvar i = 0; i < 4; i++) begin : g_mul
    assign a[i] = col_i[31-8*i -: 8];
    xtime u_x2 (.in_i(a[i]),  .out_o(x2[i]));
    xtime u_x4 (.in_i(x2[i]), .out_o(x4[i]));
    xtime u_x8 (.in_i(x4[i]), .out_o(x8[i]));
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  // Row j of the circulant matrix: 0e on the diagonal, then 0b, 0d, 09.
  for (genvar j = 0; j < 4; j++) begin : g_row
    assign col_o[31-8*j -: 8] = me[j] ^ mb[(j+1)%4] ^ md[(j+2)%4] ^ m9[(j+3)%4];
  end
endmodule

// File: rtl/inv_sbox.sv
// Inverse AES S-box as a 256-entry combinational lookup.
module inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign out_o = TBL[{~in_i, 3'b000} +: 8];
endmodule

// File: rtl/sbox.sv
// Forward AES S-box as a 256-entry combinational lookup.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Entry 0 sits in the top byte; ~in_i turns the byte value into a slot
  // counted from the LSB end.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_o = TBL[{~in_i, 3'b000} +: 8];
endmodule

// File: rtl/xtime.sv
// Multiply a GF(2^8) element by x (0x02), reducing by 0x11b.
module xtime (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  assign out_o = {in_i[6:0], 1'b0} ^ (in_i[7] ? 8'h1b : 8'h00);
endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher. Round keys are produced on the fly:
// ten forward expansion steps reach K10, then the schedule is walked
// backwards one step per decryption round.
module aes_128_decrypt
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BLOCK_LENGTH-1:0] in_state,
  input  logic [KEY_SIZE-1:0]     in_key,
  output logic [BLOCK_LENGTH-1:0] out_state,
  output logic                    done
);
  dec_state_t fsm_q, fsm_d;
  block_t     state_q, state_d, key_q, key_d, out_q, out_d;
  logic [3:0] rnd_q, rnd_d;
  logic       done_q, done_d;

  // ---------------- key schedule (both directions) ----------------
  word_t w0, w1, w2, w3;
  word_t iw0, iw1, iw2, iw3;
  word_t fw0, fw1, fw2, fw3;
  word_t sub_in, sub_out;
  byte_t rcon_b;
  block_t key_fwd, key_inv;

  assign {w0, w1, w2, w3} = key_q;

  assign iw3 = w3 ^ w2;
  assign iw2 = w2 ^ w1;
  assign iw1 = w1 ^ w0;

  // One SubWord serves both walks: the forward step substitutes w3, the
  // backward step the recovered w3'.
  assign sub_in = rot_word((fsm_q == KEY_FWD) ? w3 : iw3);

  for (genvar b = 0; b < 4; b++) begin : g_subword
    sbox u_sbox (.in_i(sub_in[31-8*b -: 8]), .out_o(sub_out[31-8*b -: 8]));
  end

  assign rcon_b = (fsm_q == ADD0) ? RCON[ROUNDS] : RCON[rnd_q];

  assign fw0 = w0 ^ sub_out ^ {rcon_b, 24'h000000};
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;
  assign iw0 = w0 ^ sub_out ^ {rcon_b, 24'h000000};

  assign key_fwd = {fw0, fw1, fw2, fw3};
  assign key_inv = {iw0, iw1, iw2, iw3};

  // ---------------- round datapath ----------------
  block_t isb, ark, imc;

  for (genvar i = 0; i < 16; i++) begin : g_inv_sub
    inv_sbox u_inv_sbox (
      .in_i (state_q[BLOCK_LENGTH-1-8*INV_SR_IDX[i] -: 8]),
      .out_o(isb[BLOCK_LENGTH-1-8*i -: 8])
    );
  end

  assign ark = isb ^ key_q;

  for (genvar c = 0; c < 4; c++) begin : g_inv_mix
    inv_mix_column u_inv_mix (
      .col_i(ark[BLOCK_LENGTH-1-32*c -: 32]),
      .col_o(imc[BLOCK_LENGTH-1-32*c -: 32])
    );
  end

  // ---------------- control ----------------
  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic: start is only looked at in IDLE
  always_comb begin
    // NOTE: default first so no path through the case leaves fsm_d unassigned (no latch)
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = KEY_FWD;
      KEY_FWD: if (rnd_q == 4'(ROUNDS)) fsm_d = ADD0;
      ADD0:    fsm_d = ROUND;
      ROUND:   if (rnd_q == 4'd0) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath next values per state: load, forward key walk, initial
  // AddRoundKey, then decryption rounds with the backward key walk
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = in_state;
          key_d   = in_key;
          rnd_d   = 4'd1;
        end
      end
      KEY_FWD: begin
        key_d = key_fwd;
        rnd_d = rnd_q + 4'd1;
      end
      ADD0: begin
        state_d = state_q ^ key_q;
        key_d   = key_inv;
        rnd_d   = 4'(ROUNDS - 1);
      end
      ROUND: begin
        if (rnd_q == 4'd0) begin
          state_d = ark;
          out_d   = ark;
          done_d  = 1'b1;
        end else begin
          state_d = imc;
          key_d   = key_inv;
          rnd_d   = rnd_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any block in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out_state = out_q;
  assign done      = done_q;
endmodule

// File: tb/tb_aes_128_decrypt.sv
// Self-checking bench for aes_128_decrypt: known-answer vectors, latency,
// back-to-back, ignored start, mid-operation reset and random loopback
// through a behavioural forward cipher.
module tb_aes_128_decrypt;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst, start, done;
  block_t in_state, in_key, out_state;

  int n_tests = 0;
  int n_fail  = 0;

  aes_128_decrypt dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_state (in_state),
    .in_key   (in_key),
    .out_state(out_state),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    block_t key;
    block_t ct;
    block_t pt;
    logic   has_k10;
    block_t k10;
  } vec_t;

  vec_t  vecs [3];
  byte_t sb_tab [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural forward cipher ----------------
  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    byte_t inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic block_t encrypt(block_t key, block_t pt);
    word_t  w [44];
    word_t  tmp;
    byte_t  s [16], t [16];
    byte_t  rc, a0, a1, a2, a3;
    block_t res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tab[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Present a request; returns 1 time unit after the sampling edge E0.
  task automatic launch(input block_t key, input block_t ct);
    @(negedge clk);
    in_key   = key;
    in_state = ct;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Count edges after E0 until done is seen (-1 if it never comes);
  // optionally probe the round-key register right after E10.
  task automatic wait_done(output int lat, input logic probe, input block_t k10, input string name);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (probe && i == 10) check({name, "_k10"}, dut.key_q, k10);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     lat, ndone;
    block_t k, p, c;

    rst = 1'b1; start = 1'b0; in_state = '0; in_key = '0;
    build_sbox();

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff, has_k10: 1'b1,
                k10: 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734, has_k10: 1'b1,
                k10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt: 128'h0, has_k10: 1'b0, k10: 128'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out_state, 128'h0);
    check("reset_done", {127'h0, done}, 128'h0);
    rst = 1'b0;

    // Known-answer table: latency, result, single-cycle pulse, hold
    for (int v = 0; v < 3; v++) begin
      launch(vecs[v].key, vecs[v].ct);
      wait_done(lat, vecs[v].has_k10, vecs[v].k10, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'd21);
      check($sformatf("vec%0d_out", v), out_state, vecs[v].pt);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", v), {127'h0, done}, 128'h0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_hold", v), out_state, vecs[v].pt);
    end

    // Back-to-back: second start presented during the done cycle
    launch(vecs[0].key, vecs[0].ct);
    wait_done(lat, 1'b0, '0, "b2b_a");
    check("b2b_first_latency", 128'(lat), 128'd21);
    check("b2b_first_out", out_state, vecs[0].pt);
    launch(vecs[1].key, vecs[1].ct);
    wait_done(lat, 1'b0, '0, "b2b_b");
    check("b2b_second_latency", 128'(lat), 128'd21);
    check("b2b_second_out", out_state, vecs[1].pt);

    // start held high while busy, inputs changed mid-operation
    @(negedge clk);
    in_key = vecs[0].key; in_state = vecs[0].ct; start = 1'b1;
    @(posedge clk); #1;
    lat = -1; ndone = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 3) begin in_key = vecs[1].key; in_state = vecs[1].ct; end
      if (i == 19) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    check("held_start_done_count", 128'(ndone), 128'd1);
    check("held_start_latency", 128'(lat), 128'd21);
    check("held_start_out", out_state, vecs[0].pt);

    // Reset sampled at E15 of an operation
    launch(vecs[1].key, vecs[1].ct);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out", out_state, 128'h0);
    check("midrst_done", {127'h0, done}, 128'h0);
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_pulse", 128'(ndone), 128'd0);
    check("midrst_out_still_zero", out_state, 128'h0);
    launch(vecs[0].key, vecs[0].ct);
    wait_done(lat, 1'b0, '0, "after_rst");
    check("after_rst_latency", 128'(lat), 128'd21);
    check("after_rst_out", out_state, vecs[0].pt);

    // Random loopback through the behavioural forward cipher
    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = encrypt(k, p);
      launch(k, c);
      wait_done(lat, 1'b0, '0, "loop");
      check($sformatf("loop%0d_out", n), out_state, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
